// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed seven-segment driver with frame-aligned double buffering.
module seg7_scan_driver #(
   parameter int REFRESH_DIV   = 100000,
   parameter int BLANK_CYCLES  = 1000,
   parameter int BLANK_LEADING = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] data,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  digit_en,
   output logic [7:0]  AN,
   output logic [6:0]  A2G,
   output logic        DP,
   output logic        frame_done
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

   logic [CW-1:0] count_q, count_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   act_data_q, act_data_d, pend_data_q, pend_data_d;
   logic [7:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic [7:0]    act_en_q, act_en_d, pend_en_q, pend_en_d;
   logic          pend_valid_q, pend_valid_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    a2g_q, a2g_d;
   logic          dp_q, dp_d, fd_q, fd_d;
   logic          tick, boundary, zero_run, blank;
   logic [7:0]    lz, vis;
   logic [3:0]    nib;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b0000001;
         4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;
         4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;
         4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;
         4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0000100;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;
         4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   assign tick     = count_q == LAST;
   assign boundary = tick && idx_q == 3'd7;

   always_comb begin
      count_d      = tick ? '0 : count_q + 1'b1;
      idx_d        = tick ? idx_q + 3'd1 : idx_q;
      pend_data_d  = load ? data : pend_data_q;
      pend_dp_d    = load ? dp_mask : pend_dp_q;
      pend_en_d    = load ? digit_en : pend_en_q;
      pend_valid_d = boundary ? 1'b0 : (load | pend_valid_q);
      // A load landing on the boundary bypasses pending so it is not delayed a whole frame
      act_data_d   = !boundary ? act_data_q : load ? data : pend_valid_q ? pend_data_q : act_data_q;
      act_dp_d     = !boundary ? act_dp_q : load ? dp_mask : pend_valid_q ? pend_dp_q : act_dp_q;
      act_en_d     = !boundary ? act_en_q : load ? digit_en : pend_valid_q ? pend_en_q : act_en_q;
      fd_d         = boundary;
   end

   always_comb begin
      zero_run = 1'b1;
      lz       = '0;
      for (int i = 7; i >= 0; i--) begin
         zero_run = zero_run & (act_data_q[4*i +: 4] == 4'h0);
         lz[i]    = (BLANK_LEADING != 0) && (i != 0) && zero_run;
      end
      vis = act_en_q & ~lz;
   end

   always_comb begin
      nib   = act_data_q[{idx_q, 2'b00} +: 4];
      blank = (count_q < BLANK) || !vis[idx_q];
      an_d  = blank ? 8'hFF : ~(8'd1 << idx_q);
      a2g_d = blank ? 7'h7F : hex7(nib);
      dp_d  = blank | ~act_dp_q[idx_q];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q      <= '0;
         idx_q        <= '0;
         act_data_q   <= '0;
         act_dp_q     <= '0;
         act_en_q     <= '0;
         pend_data_q  <= '0;
         pend_dp_q    <= '0;
         pend_en_q    <= '0;
         pend_valid_q <= 1'b0;
         an_q         <= 8'hFF;
         a2g_q        <= 7'h7F;
         dp_q         <= 1'b1;
         fd_q         <= 1'b0;
      end else begin
         count_q      <= count_d;
         idx_q        <= idx_d;
         act_data_q   <= act_data_d;
         act_dp_q     <= act_dp_d;
         act_en_q     <= act_en_d;
         pend_data_q  <= pend_data_d;
         pend_dp_q    <= pend_dp_d;
         pend_en_q    <= pend_en_d;
         pend_valid_q <= pend_valid_d;
         an_q         <= an_d;
         a2g_q        <= a2g_d;
         dp_q         <= dp_d;
         fd_q         <= fd_d;
      end
   end

   assign AN         = an_q;
   assign A2G        = a2g_q;
   assign DP         = dp_q;
   assign frame_done = fd_q;
endmodule
